alu_arbiter: RTL and testbench

//   Shares one combinational alu instance between NUM_REQ requesters.

---
 rtl/alu_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one alu between NUM_REQ issue sources.
// Ports: clk, rst_n, req_valid/req_ready/req_a/req_b/req_op (per requester),
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_overflow,
//   stat_ops/stat_ovf when ALU_ARB_STATS_EN is defined.
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;
endpackage

module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [4:0]     shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[4:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (op)
      ALU_ADD: begin
        result   = sum[WIDTH-1:0];
        overflow = sum[WIDTH];
      end
      ALU_SUB: begin
        result   = diff[WIDTH-1:0];
        overflow = diff[WIDTH];
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(WIDTH-1){1'b0}},
                          $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  input  alu_op_t [NUM_REQ-1:0]           req_op,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [WIDTH-1:0]                rsp_result,
  output logic                            rsp_zero,
  output logic                            rsp_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]                     stat_ops,
  output logic [31:0]                     stat_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   last_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   win;
  logic              any_req;
  int                idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  alu_op_t           op_q;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_zero;
  logic              alu_ovf;
  logic              rsp_fire;

  assign rsp_fire = rsp_valid & rsp_ready;

  // Search starts one past the last accepted requester and wraps.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && any_req)
      req_ready[win] = 1'b1;
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_res),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_ADD;
      id_q         <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            a_q  <= req_a[win];
            b_q  <= req_b[win];
            op_q <= req_op[win];
            id_q <= win;
          end
        end
        S_EXEC: begin
          rsp_valid    <= 1'b1;
          rsp_id       <= id_q;
          rsp_result   <= alu_res;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_ovf;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_q    <= rsp_id;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (rsp_fire) begin
      if (stat_ops != '1)
        stat_ops <= stat_ops + 32'd1;
      if (rsp_overflow && stat_ovf != '1)
        stat_ovf <= stat_ovf + 32'd1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed steps with a response scoreboard
// for alu_arbiter (WIDTH=32, NUM_REQ=4).
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][W-1:0]  req_a;
  logic [N-1:0][W-1:0]  req_b;
  alu_op_t [N-1:0]      req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [W-1:0]         rsp_result;
  logic                 rsp_zero;
  logic                 rsp_overflow;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]          stat_ops;
  logic [31:0]          stat_ovf;
`endif

  alu_arbiter #(
    .WIDTH   (W),
    .NUM_REQ (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] res;
    logic         z;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   grant_ids[$];
  int   grant_cycs[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  int   rsp_cyc = 0;
  int   model_last = N - 1;
  exp_t obs;

  function automatic exp_t model(int id, logic [W-1:0] a,
                                 logic [W-1:0] b, alu_op_t op);
    logic [W:0] t;
    exp_t       e;
    e.id  = id[1:0];
    e.res = '0;
    e.o   = 1'b0;
    case (op)
      ALU_ADD: begin
        t     = {1'b0, a} + {1'b0, b};
        e.res = t[W-1:0];
        e.o   = t[W];
      end
      ALU_SUB: begin
        e.res = a - b;
        e.o   = (a < b);
      end
      ALU_AND:  e.res = a & b;
      ALU_OR:   e.res = a | b;
      ALU_XOR:  e.res = a ^ b;
      ALU_SLL:  e.res = a << b[4:0];
      ALU_SRL:  e.res = a >> b[4:0];
      ALU_SRA:  e.res = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_SLTU: e.res = (a < b) ? 1 : 0;
      default:  e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic int rr_win(logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(model_last + i) % N]) return (model_last + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [W-1:0] o,
                     logic [W-1:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic cycle();
    int         w;
    logic [N-1:0] m;
    exp_t       e;
    @(negedge clk);
    cyc++;
    if (req_ready != '0) begin
      w = rr_win(req_valid);
      m = '0;
      if (w >= 0) m[w] = 1'b1;
      chk("grant_mask", 32'(req_ready), 32'(m));
      if (w >= 0) begin
        sb.push_back(model(w, req_a[w], req_b[w], req_op[w]));
        grant_ids.push_back(w);
        grant_cycs.push_back(cyc);
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      rsp_cyc    = cyc;
      obs.id     = rsp_id;
      obs.res    = rsp_result;
      obs.z      = rsp_zero;
      obs.o      = rsp_overflow;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_result", rsp_result, e.res);
        chk("sb_zero", 32'(rsp_zero), 32'(e.z));
        chk("sb_ovf", 32'(rsp_overflow), 32'(e.o));
        model_last = int'(e.id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(int bound, output int id);
    int s;
    int k;
    s = grant_ids.size();
    k = 0;
    while (grant_ids.size() == s && k < bound) begin
      cycle();
      k++;
    end
    chk("grant_timeout", grant_ids.size(), s + 1);
    id = (grant_ids.size() > s) ? grant_ids[$] : -1;
  endtask

  task automatic wait_rsp(int bound);
    int s;
    int k;
    s = n_rsp;
    k = 0;
    while (n_rsp == s && k < bound) begin
      cycle();
      k++;
    end
    chk("rsp_timeout", n_rsp, s + 1);
  endtask

  task automatic drain(int bound);
    int k;
    k = 0;
    while (sb.size() > 0 && k < bound) begin
      cycle();
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    model_last = N - 1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic one_op(int r, logic [W-1:0] a,
                        logic [W-1:0] b, alu_op_t op);
    int g;
    req_a[r]     = a;
    req_b[r]     = b;
    req_op[r]    = op;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    wait_grant(10, g);
    req_valid = '0;
    chk("op_gid", g, r);
    wait_rsp(10);
  endtask

  initial begin
    int   g;
    int   s;
    int   k;
    exp_t held;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) req_op[i] = ALU_ADD;
    cycle();
    cycle();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Single requester, 5+3
    one_op(0, 32'd5, 32'd3, ALU_ADD);
    chk("t1_latency", rsp_cyc - grant_cycs[$], 2);
    chk("t1_id", 32'(obs.id), 32'd0);
    chk("t1_result", obs.res, 32'd8);
    chk("t1_zero", 32'(obs.z), 32'd0);
    chk("t1_ovf", 32'(obs.o), 32'd0);

    // All requesting: round robin 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 32'(i * 10 + 1);
      req_b[i] = 32'(i + 1);
    end
    req_op[0] = ALU_ADD;
    req_op[1] = ALU_SUB;
    req_op[2] = ALU_XOR;
    req_op[3] = ALU_SLL;
    s = grant_ids.size();
    k = 0;
    req_valid = 4'b1111;
    while (grant_ids.size() < s + 5 && k < 40) begin
      cycle();
      k++;
    end
    req_valid = '0;
    chk("t2_count", grant_ids.size(), s + 5);
    if (grant_ids.size() == s + 5) begin
      for (int i = 0; i < 5; i++)
        chk("t2_order", grant_ids[s + i], i % N);
      for (int i = 1; i < 5; i++)
        chk("t2_gap", grant_cycs[s + i] - grant_cycs[s + i - 1], 3);
    end
    drain(20);

    // Flags
    one_op(0, 32'd7, 32'd7, ALU_SUB);
    chk("t3_sub_res", obs.res, 32'd0);
    chk("t3_sub_zero", 32'(obs.z), 32'd1);
    chk("t3_sub_ovf", 32'(obs.o), 32'd0);
    one_op(0, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
    chk("t3_add_res", obs.res, 32'd0);
    chk("t3_add_zero", 32'(obs.z), 32'd1);
    chk("t3_add_ovf", 32'(obs.o), 32'd1);

    // Backpressure
    rsp_ready = 1'b0;
    req_a[1]  = 32'd100;
    req_b[1]  = 32'd1;
    req_op[1] = ALU_SUB;
    req_a[2]  = 32'd3;
    req_b[2]  = 32'd4;
    req_op[2] = ALU_SUB;
    req_valid = 4'b0110;
    wait_grant(10, g);
    chk("t4_first", g, 1);
    k = 0;
    while (!rsp_valid && k < 10) begin
      cycle();
      k++;
    end
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    held.id  = rsp_id;
    held.res = rsp_result;
    held.z   = rsp_zero;
    held.o   = rsp_overflow;
    chk("t4_res", held.res, 32'd99);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_id", 32'(rsp_id), 32'(held.id));
      chk("t4_hold_res", rsp_result, held.res);
      chk("t4_hold_flags", 32'({rsp_zero, rsp_overflow}),
          32'({held.z, held.o}));
      chk("t4_no_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    wait_grant(10, g);
    req_valid = '0;
    chk("t4_next", g, 2);
    drain(20);

    // Reset with req 2 in EXEC
    req_a[2]  = 32'd9;
    req_b[2]  = 32'd9;
    req_op[2] = ALU_ADD;
    req_valid = 4'b0100;
    wait_grant(10, g);
    chk("t5_grant", g, 2);
    rst_n     = 1'b0;
    req_valid = '0;
    sb.delete();
    model_last = N - 1;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    s = n_rsp;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_no_rsp", n_rsp, s);
    chk("t5_rsp_valid2", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    wait_grant(10, g);
    req_valid = '0;
    chk("t5_first", g, 0);
    drain(20);

`ifdef ALU_ARB_STATS_EN
    apply_reset();
    chk("t6_ops0", stat_ops, 32'd0);
    one_op(0, 32'd1, 32'd2, ALU_ADD);
    one_op(1, 32'hFFFF_FFFF, 32'd2, ALU_ADD);
    one_op(2, 32'hF0, 32'h0F, ALU_XOR);
    chk("t6_ops", stat_ops, 32'd3);
    chk("t6_ovf", stat_ovf, 32'd1);
    force dut.stat_ops = 32'hFFFF_FFFF;
    force dut.stat_ovf = 32'hFFFF_FFFF;
    #1;
    release dut.stat_ops;
    release dut.stat_ovf;
    one_op(3, 32'hFFFF_FFFF, 32'd5, ALU_ADD);
    one_op(0, 32'd1, 32'd1, ALU_ADD);
    chk("t6_ops_sat", stat_ops, 32'hFFFF_FFFF);
    chk("t6_ovf_sat", stat_ovf, 32'hFFFF_FFFF);
`endif

    drain(20);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
